// File: rtl/cpu_debug_ocimem_arbiter_pkg.sv
// Shared types for the OCI RAM arbiter: FSM states, grant owner and the arbitration rule.
package cpu_debug_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DATA_W     = 32;

   typedef enum logic [1:0] {IDLE, ACC, RSP} state_e;
   typedef enum logic {GNT_CPU, GNT_JTAG} grant_e;

   // JTAG owns the RAM while the CPU is halted; otherwise ties alternate against the last winner.
   function automatic grant_e arbitrate(input logic cpuReq, input logic jtagReq,
                                        input logic debugack, input grant_e lastGnt);
      if (!jtagReq) return GNT_CPU;
      if (!cpuReq) return GNT_JTAG;
      if (debugack) return GNT_JTAG;
      return (lastGnt == GNT_JTAG) ? GNT_CPU : GNT_JTAG;
   endfunction

endpackage

// File: rtl/cpu_debug_ocimem_arbiter_if.sv
// Bundles the JTAG strobes, CPU Avalon slave and OCI RAM port seen by the arbiter.
interface cpu_debug_ocimem_arbiter_if import cpu_debug_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W
);
   logic              debugack;
   logic              jtag_addr_load;
   logic [ADDR_W-1:0] jtag_addr_in;
   logic              jtag_access;
   logic              jtag_write;
   logic [DATA_W-1:0] jtag_wdata;
   logic [DATA_W-1:0] mon_dreg;
   logic              jtag_done;
   logic              jtag_overrun;
   logic              cpu_read;
   logic              cpu_write;
   logic [ADDR_W-1:0] cpu_address;
   logic [DATA_W-1:0] cpu_writedata;
   logic [3:0]        cpu_byteenable;
   logic [DATA_W-1:0] cpu_readdata;
   logic              cpu_waitrequest;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [3:0]        ram_be;
   logic              ram_we;
   logic              ram_re;
   logic [DATA_W-1:0] ram_rdata;

   // The arbiter is the slave of both requesters and drives the RAM port.
   modport slave (
      input  debugack, jtag_addr_load, jtag_addr_in, jtag_access, jtag_write, jtag_wdata,
      input  cpu_read, cpu_write, cpu_address, cpu_writedata, cpu_byteenable, ram_rdata,
      output mon_dreg, jtag_done, jtag_overrun, cpu_readdata, cpu_waitrequest,
      output ram_addr, ram_wdata, ram_be, ram_we, ram_re
   );

   modport master (
      output debugack, jtag_addr_load, jtag_addr_in, jtag_access, jtag_write, jtag_wdata,
      output cpu_read, cpu_write, cpu_address, cpu_writedata, cpu_byteenable, ram_rdata,
      input  mon_dreg, jtag_done, jtag_overrun, cpu_readdata, cpu_waitrequest,
      input  ram_addr, ram_wdata, ram_be, ram_we, ram_re
   );
endinterface

// File: rtl/cpu_debug_ocimem_arbiter_jtag_port.sv
// JTAG side of the arbiter: auto-incrementing address, one-deep request latch and sticky overrun.
module ocimem_jtag_port import cpu_debug_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              addrLoad_i,
   input  logic [ADDR_W-1:0] addrIn_i,
   input  logic              access_i,
   input  logic              write_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              busy_i,
   input  logic              take_i,
   input  logic              inc_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              pend_o,
   output logic              write_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              overrun_o
);
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              pend_q, pend_d, write_q, write_d, overrun_q, overrun_d;
   logic              drop;

   // A strobe that arrives while one is queued or being served has nowhere to go.
   always_comb begin
      drop      = access_i & (pend_q | busy_i);
      addr_d    = addr_q;
      pend_d    = pend_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      overrun_d = overrun_q;
      if (addrLoad_i) addr_d = addrIn_i;
      else if (inc_i) addr_d = addr_q + ADDR_W'(1);
      if (take_i) pend_d = 1'b0;
      if (access_i && !drop) begin
         pend_d  = 1'b1;
         write_d = write_i;
         wdata_d = wdata_i;
      end
      if (addrLoad_i) overrun_d = 1'b0;
      if (drop) overrun_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q    <= '0;
         pend_q    <= 1'b0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         addr_q    <= addr_d;
         pend_q    <= pend_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         overrun_q <= overrun_d;
      end
   end

   assign addr_o    = addr_q;
   assign pend_o    = pend_q;
   assign write_o   = write_q;
   assign wdata_o   = wdata_q;
   assign overrun_o = overrun_q;
endmodule

// File: rtl/cpu_debug_ocimem_arbiter.sv
// Serialises CPU debug-memory and JTAG accesses onto the single-port OCI RAM (1-cycle read latency).
module cpu_debug_ocimem_arbiter import cpu_debug_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input logic                       clk,
   input logic                       reset,
   cpu_debug_ocimem_arbiter_if.slave bus
);
   state_e            state_q;
   grant_e            gnt_q, lastGnt_q, winner;
   logic [ADDR_W-1:0] ramAddr_q, jtagAddr;
   logic [DATA_W-1:0] ramWdata_q, monDreg_q, jtagWdata;
   logic [3:0]        ramBe_q;
   logic              ramWe_q, ramRe_q, accWrite_q, jtagDone_q;
   logic              cpuReq, cpuRsp, jtagBusy, jtagTake, jtagInc;
   logic              jtagPend, jtagWrite, jtagOverrun;

   assign cpuReq   = bus.cpu_read | bus.cpu_write;
   assign winner   = arbitrate(cpuReq, jtagPend, bus.debugack, lastGnt_q);
   assign jtagTake = (state_q == IDLE) && jtagPend && (winner == GNT_JTAG);
   assign jtagBusy = (state_q != IDLE) && (gnt_q == GNT_JTAG);
   assign jtagInc  = (state_q == RSP) && (gnt_q == GNT_JTAG);
   assign cpuRsp   = (state_q == RSP) && (gnt_q == GNT_CPU);

   ocimem_jtag_port #(.ADDR_W(ADDR_W)) jtagPort (
      .clk        (clk),
      .reset      (reset),
      .addrLoad_i (bus.jtag_addr_load),
      .addrIn_i   (bus.jtag_addr_in),
      .access_i   (bus.jtag_access),
      .write_i    (bus.jtag_write),
      .wdata_i    (bus.jtag_wdata),
      .busy_i     (jtagBusy),
      .take_i     (jtagTake),
      .inc_i      (jtagInc),
      .addr_o     (jtagAddr),
      .pend_o     (jtagPend),
      .write_o    (jtagWrite),
      .wdata_o    (jtagWdata),
      .overrun_o  (jtagOverrun)
   );

   // RAM controls are registered on the IDLE->ACC edge so they are valid for exactly the ACC cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         gnt_q      <= GNT_JTAG;
         lastGnt_q  <= GNT_JTAG;
         ramAddr_q  <= '0;
         ramWdata_q <= '0;
         ramBe_q    <= '0;
         ramWe_q    <= 1'b0;
         ramRe_q    <= 1'b0;
         accWrite_q <= 1'b0;
         jtagDone_q <= 1'b0;
         monDreg_q  <= '0;
      end else begin
         ramWe_q    <= 1'b0;
         ramRe_q    <= 1'b0;
         jtagDone_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cpuReq || jtagPend) begin
                  state_q   <= ACC;
                  gnt_q     <= winner;
                  lastGnt_q <= winner;
                  if (winner == GNT_JTAG) begin
                     ramAddr_q  <= jtagAddr;
                     ramWdata_q <= jtagWdata;
                     ramBe_q    <= 4'hF;
                     ramWe_q    <= jtagWrite;
                     ramRe_q    <= ~jtagWrite;
                     accWrite_q <= jtagWrite;
                  end else begin
                     ramAddr_q  <= bus.cpu_address;
                     ramWdata_q <= bus.cpu_writedata;
                     ramBe_q    <= bus.cpu_byteenable;
                     ramWe_q    <= bus.cpu_write;
                     ramRe_q    <= bus.cpu_read;
                     accWrite_q <= bus.cpu_write;
                  end
               end
            end
            ACC: begin
               state_q    <= RSP;
               jtagDone_q <= (gnt_q == GNT_JTAG);
            end
            RSP: begin
               state_q <= IDLE;
               if (gnt_q == GNT_JTAG && !accWrite_q) monDreg_q <= bus.ram_rdata;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.cpu_waitrequest = cpuReq & ~cpuRsp;
   assign bus.cpu_readdata    = cpuRsp ? bus.ram_rdata : '0;
   assign bus.mon_dreg        = monDreg_q;
   assign bus.jtag_done       = jtagDone_q;
   assign bus.jtag_overrun    = jtagOverrun;
   assign bus.ram_addr        = ramAddr_q;
   assign bus.ram_wdata       = ramWdata_q;
   assign bus.ram_be          = ramBe_q;
   assign bus.ram_we          = ramWe_q;
   assign bus.ram_re          = ramRe_q;
endmodule

// File: tb/tb_cpu_debug_ocimem_arbiter.sv
// Bench for the OCI RAM arbiter: directed scenarios plus random CPU/JTAG traffic against a memory model.
module tb_cpu_debug_ocimem_arbiter;

   typedef struct {
      logic [7:0]  addr;
      logic        we;
      logic        re;
      logic [3:0]  be;
      logic [31:0] wdata;
   } accRec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ramMem [256];
   logic [31:0] refMem [256];
   logic [31:0] refMon;
   int          refJtagAddr;
   int          assertCount = 0;
   int          failCount = 0;
   accRec_t     grantLog[$];

   cpu_debug_ocimem_arbiter_if #(.ADDR_W(8)) bus();

   cpu_debug_ocimem_arbiter #(.ADDR_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] seedWord(input int i);
      return 32'hC0DE0000 ^ (32'(i) * 32'h00010301);
   endfunction

   function automatic logic [31:0] beMask(input logic [3:0] be);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
      return m;
   endfunction

   // Single-port RAM with one-cycle read latency; reloads known contents whenever reset is held.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) ramMem[i] <= seedWord(i);
         bus.ram_rdata <= '0;
      end else begin
         if (bus.ram_we)
            ramMem[bus.ram_addr] <= (ramMem[bus.ram_addr] & ~beMask(bus.ram_be)) |
                                    (bus.ram_wdata & beMask(bus.ram_be));
         if (bus.ram_re) bus.ram_rdata <= ramMem[bus.ram_addr];
      end
   end

   // Every cycle the RAM is driven is one granted access.
   always @(negedge clk) begin
      if (bus.ram_we || bus.ram_re)
         grantLog.push_back('{bus.ram_addr, bus.ram_we, bus.ram_re, bus.ram_be, bus.ram_wdata});
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: time limit reached, observed hang, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic initRefs();
      for (int i = 0; i < 256; i++) refMem[i] = seedWord(i);
      refJtagAddr = 0;
      refMon      = '0;
   endtask

   task automatic applyStimulus();
      bus.debugack       = 1'b0;
      bus.jtag_addr_load = 1'b0;
      bus.jtag_addr_in   = '0;
      bus.jtag_access    = 1'b0;
      bus.jtag_write     = 1'b0;
      bus.jtag_wdata     = '0;
      bus.cpu_read       = 1'b0;
      bus.cpu_write      = 1'b0;
      bus.cpu_address    = '0;
      bus.cpu_writedata  = '0;
      bus.cpu_byteenable = '0;
   endtask

   task automatic resetDut();
      applyStimulus();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      initRefs();
   endtask

   task automatic checkResetValues(input string pfx);
      checkOutput({pfx, "MonDreg"}, bus.mon_dreg, 32'h0);
      checkOutput({pfx, "JtagDone"}, bus.jtag_done, 1'b0);
      checkOutput({pfx, "Overrun"}, bus.jtag_overrun, 1'b0);
      checkOutput({pfx, "RamWe"}, bus.ram_we, 1'b0);
      checkOutput({pfx, "RamRe"}, bus.ram_re, 1'b0);
      checkOutput({pfx, "RamAddr"}, bus.ram_addr, 8'h00);
      checkOutput({pfx, "RamWdata"}, bus.ram_wdata, 32'h0);
      checkOutput({pfx, "RamBe"}, bus.ram_be, 4'h0);
      checkOutput({pfx, "CpuReaddata"}, bus.cpu_readdata, 32'h0);
      checkOutput({pfx, "CpuWait"}, bus.cpu_waitrequest, 1'b0);
   endtask

   task automatic jtagLoad(input logic [7:0] addr);
      bus.jtag_addr_load = 1'b1;
      bus.jtag_addr_in   = addr;
      tick();
      bus.jtag_addr_load = 1'b0;
      refJtagAddr = int'(addr);
   endtask

   task automatic jtagAccess(input logic wr, input logic [31:0] data,
                             input logic loadInRsp, input logic [7:0] loadAddr);
      logic [7:0] accAddr;
      int         cycles;
      accAddr = 8'(refJtagAddr);
      grantLog.delete();
      bus.jtag_access = 1'b1;
      bus.jtag_write  = wr;
      bus.jtag_wdata  = data;
      tick();
      bus.jtag_access = 1'b0;
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (!bus.jtag_done && cycles < 10);
      checkOutput("jtagDoneLatency", cycles, 2);
      checkOutput("jtagAccCount", grantLog.size(), 1);
      if (grantLog.size() > 0) begin
         checkOutput("jtagRamAddr", grantLog[0].addr, accAddr);
         checkOutput("jtagRamWe", grantLog[0].we, wr);
         checkOutput("jtagRamRe", grantLog[0].re, !wr);
         checkOutput("jtagRamBe", grantLog[0].be, 4'hF);
         if (wr) checkOutput("jtagRamWdata", grantLog[0].wdata, data);
      end
      if (loadInRsp) begin
         bus.jtag_addr_load = 1'b1;
         bus.jtag_addr_in   = loadAddr;
      end
      tick();
      bus.jtag_addr_load = 1'b0;
      checkOutput("jtagDonePulse", bus.jtag_done, 1'b0);
      if (wr) refMem[accAddr] = data;
      else refMon = refMem[accAddr];
      checkOutput("jtagMonDreg", bus.mon_dreg, refMon);
      refJtagAddr = loadInRsp ? int'(loadAddr) : (refJtagAddr + 1) % 256;
   endtask

   task automatic cpuAccess(input logic wr, input logic [7:0] addr,
                            input logic [31:0] data, input logic [3:0] be);
      int cycles;
      grantLog.delete();
      bus.cpu_read       = !wr;
      bus.cpu_write      = wr;
      bus.cpu_address    = addr;
      bus.cpu_writedata  = data;
      bus.cpu_byteenable = be;
      #1;
      checkOutput("cpuWaitHigh", bus.cpu_waitrequest, 1'b1);
      cycles = 0;
      while (bus.cpu_waitrequest && cycles < 10) begin
         tick();
         cycles++;
      end
      checkOutput("cpuLatency", cycles, 2);
      if (!wr) checkOutput("cpuReaddata", bus.cpu_readdata, refMem[addr]);
      checkOutput("cpuAccCount", grantLog.size(), 1);
      if (grantLog.size() > 0) begin
         checkOutput("cpuRamAddr", grantLog[0].addr, addr);
         checkOutput("cpuRamWe", grantLog[0].we, wr);
         if (wr) begin
            checkOutput("cpuRamBe", grantLog[0].be, be);
            checkOutput("cpuRamWdata", grantLog[0].wdata, data);
         end
      end
      if (wr) refMem[addr] = (refMem[addr] & ~beMask(be)) | (data & beMask(be));
      bus.cpu_read  = 1'b0;
      bus.cpu_write = 1'b0;
      tick();
      checkOutput("cpuWaitIdle", bus.cpu_waitrequest, 1'b0);
   endtask

   task automatic tieRound(input logic dbg, input logic jtagFirst);
      logic [7:0] jAddr, cAddr;
      logic       cpuDone, jDone;
      int         cycles;
      jAddr = 8'(refJtagAddr);
      cAddr = jAddr ^ 8'h80;
      bus.debugack = dbg;
      grantLog.delete();
      bus.jtag_write  = 1'b0;
      bus.jtag_access = 1'b1;
      tick();
      bus.jtag_access    = 1'b0;
      bus.cpu_read       = 1'b1;
      bus.cpu_address    = cAddr;
      bus.cpu_byteenable = 4'hF;
      cpuDone = 1'b0;
      jDone   = 1'b0;
      cycles  = 0;
      while (!(cpuDone && jDone) && cycles < 20) begin
         tick();
         cycles++;
         if (bus.jtag_done) jDone = 1'b1;
         if (bus.cpu_read && !bus.cpu_waitrequest) begin
            checkOutput("tieCpuReaddata", bus.cpu_readdata, refMem[cAddr]);
            bus.cpu_read = 1'b0;
            cpuDone = 1'b1;
         end
      end
      checkOutput("tieBothDone", {cpuDone, jDone}, 2'b11);
      tick();
      checkOutput("tieGrantCount", grantLog.size(), 2);
      if (grantLog.size() == 2) begin
         checkOutput("tieFirstGrant", grantLog[0].addr, jtagFirst ? jAddr : cAddr);
         checkOutput("tieSecondGrant", grantLog[1].addr, jtagFirst ? cAddr : jAddr);
      end
      refMon      = refMem[jAddr];
      refJtagAddr = (refJtagAddr + 1) % 256;
      checkOutput("tieMonDreg", bus.mon_dreg, refMon);
      bus.debugack = 1'b0;
   endtask

   task automatic overrunTest();
      logic [7:0] aAddr;
      aAddr = 8'(refJtagAddr);
      checkOutput("ovrInitial", bus.jtag_overrun, 1'b0);
      grantLog.delete();
      bus.jtag_write  = 1'b0;
      bus.jtag_access = 1'b1;
      tick();
      bus.jtag_access = 1'b0;
      tick();
      bus.jtag_access = 1'b1;
      tick();
      bus.jtag_access = 1'b0;
      repeat (5) tick();
      checkOutput("ovrAccCount", grantLog.size(), 1);
      checkOutput("ovrSticky", bus.jtag_overrun, 1'b1);
      refMon      = refMem[aAddr];
      refJtagAddr = (refJtagAddr + 1) % 256;
      checkOutput("ovrMonDreg", bus.mon_dreg, refMon);
      jtagLoad(8'h22);
      checkOutput("ovrCleared", bus.jtag_overrun, 1'b0);
   endtask

   task automatic resetMidAccess();
      bus.jtag_write  = 1'b1;
      bus.jtag_wdata  = 32'hA5A5_0F0F;
      bus.jtag_access = 1'b1;
      tick();
      bus.jtag_access = 1'b0;
      tick();
      checkOutput("midAccWe", bus.ram_we, 1'b1);
      reset = 1'b1;
      tick();
      checkResetValues("mid");
      reset = 1'b0;
      initRefs();
      grantLog.delete();
      repeat (5) tick();
      checkOutput("midNoAccess", grantLog.size(), 0);
   endtask

   initial begin
      resetDut();
      checkResetValues("rst");

      jtagLoad(8'h10);
      jtagAccess(1'b1, 32'hDEADBEEF, 1'b0, 8'h00);
      jtagAccess(1'b0, 32'h0, 1'b0, 8'h00);
      jtagLoad(8'h10);
      jtagAccess(1'b0, 32'h0, 1'b0, 8'h00);
      checkOutput("monDeadbeef", bus.mon_dreg, 32'hDEADBEEF);

      jtagLoad(8'h05);
      jtagAccess(1'b1, 32'h12345678, 1'b0, 8'h00);
      cpuAccess(1'b0, 8'h05, 32'h0, 4'hF);
      checkOutput("cpuRead12345678", refMem[5], 32'h12345678);

      jtagLoad(8'hFF);
      jtagAccess(1'b1, 32'h0BAD_F00D, 1'b0, 8'h00);
      jtagAccess(1'b0, 32'h0, 1'b1, 8'h40);
      jtagAccess(1'b0, 32'h0, 1'b0, 8'h00);

      overrunTest();

      for (int n = 0; n < 40; n++) begin
         bus.debugack = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0: jtagLoad(8'($urandom_range(0, 255)));
            1: jtagAccess(1'b1, $urandom, 1'b0, 8'h00);
            2: jtagAccess(1'b0, 32'h0, 1'b0, 8'h00);
            3: cpuAccess(1'b1, 8'($urandom_range(0, 255)), $urandom, 4'($urandom_range(1, 15)));
            default: cpuAccess(1'b0, 8'($urandom_range(0, 255)), 32'h0, 4'hF);
         endcase
      end
      bus.debugack = 1'b0;

      resetDut();
      jtagLoad(8'h30);
      tieRound(1'b0, 1'b0);
      tieRound(1'b0, 1'b0);
      tieRound(1'b1, 1'b1);
      tieRound(1'b0, 1'b1);

      resetMidAccess();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
